// File: rtl/cpu_pkg.sv
// Shared CPU-wide register-file definitions used by the ID-stage scoreboard.
package cpu_pkg;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned NREG     = 32;
  typedef logic [RegAddrW-1:0] reg_addr_t;
  localparam reg_addr_t RegZero    = '0;
endpackage

// File: rtl/id_raw_scoreboard_if.sv
// Issue / operand / ready / flush bundle between the ID stage and the RAW scoreboard.
interface id_raw_scoreboard_if import cpu_pkg::*; #(
  parameter int unsigned NREG = cpu_pkg::NREG
) ();
  logic            issue_valid_i;
  logic            issue_we_i;
  logic            issue_late_i;
  reg_addr_t       issue_waddr_i;
  logic            id_re1_i;
  reg_addr_t       id_raddr1_i;
  logic            id_re2_i;
  reg_addr_t       id_raddr2_i;
  logic            ready_valid_i;
  reg_addr_t       ready_waddr_i;
  logic            flush_i;
  logic            stall_o;
  logic [NREG-1:0] pending_o;
  logic            err_o;

  modport master (
    output issue_valid_i, issue_we_i, issue_late_i, issue_waddr_i,
           id_re1_i, id_raddr1_i, id_re2_i, id_raddr2_i,
           ready_valid_i, ready_waddr_i, flush_i,
    input  stall_o, pending_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_we_i, issue_late_i, issue_waddr_i,
           id_re1_i, id_raddr1_i, id_re2_i, id_raddr2_i,
           ready_valid_i, ready_waddr_i, flush_i,
    output stall_o, pending_o, err_o
  );
endinterface

// File: rtl/id_raw_scoreboard_sb_counter.sv
// Per-register in-flight write counter: clear wins, simultaneous inc/dec holds.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o
);
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);
endmodule

// File: rtl/id_raw_scoreboard.sv
// ID-stage RAW scoreboard: counts late (non-forwardable) writes per GPR and stalls dependent issue.
module id_raw_scoreboard import cpu_pkg::*; #(
  parameter int unsigned NREG  = cpu_pkg::NREG,
  parameter int unsigned CNT_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  id_raw_scoreboard_if.slave  sb
);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] eff [NREG];
  logic [NREG-1:0]  rdy_hit;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  nz;
  logic             hazard, full, stall, accept, late_wr;
  logic             err_d, err_q;

  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (inc[r]),
      .dec_i   (rdy_hit[r]),
      .clr_i   (sb.flush_i),
      .cnt_o   (cnt[r]),
      .nz_o    (nz[r])
    );
  end

  always_comb begin
    rdy_hit = '0;
    inc     = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      rdy_hit[r] = sb.ready_valid_i && (sb.ready_waddr_i == reg_addr_t'(r)) && nz[r];
    end
    // A result readied this cycle is already on the bypass mux, so it no longer blocks.
    for (int unsigned r = 0; r < NREG; r++) begin
      eff[r] = cnt[r] - CNT_W'(rdy_hit[r]);
    end
    hazard  = (sb.id_re1_i && (sb.id_raddr1_i != RegZero) && (eff[sb.id_raddr1_i] != '0)) ||
              (sb.id_re2_i && (sb.id_raddr2_i != RegZero) && (eff[sb.id_raddr2_i] != '0));
    late_wr = sb.issue_valid_i && sb.issue_we_i && sb.issue_late_i && (sb.issue_waddr_i != RegZero);
    full    = late_wr && (eff[sb.issue_waddr_i] == CntMax);
    stall   = sb.issue_valid_i && (hazard || full) && !sb.flush_i;
    accept  = late_wr && !stall && !sb.flush_i;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc[r] = accept && (sb.issue_waddr_i == reg_addr_t'(r));
    end
    err_d = err_q || (sb.ready_valid_i &&
                      ((sb.ready_waddr_i == RegZero) || !nz[sb.ready_waddr_i]));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sb.stall_o   = stall;
  assign sb.pending_o = nz;
  assign sb.err_o     = err_q;
endmodule

// File: tb/tb_id_raw_scoreboard.sv
// Scoreboard bench: driver pushes model expectations per cycle, a monitor pops and compares.
module tb_id_raw_scoreboard;
  import cpu_pkg::*;

  localparam int MAXC = 3;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  id_raw_scoreboard_if #(.NREG(32)) sb_if ();

  id_raw_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sb      (sb_if)
  );

  typedef struct packed {
    logic        stall;
    logic [31:0] pend;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt_m [32];
  bit   err_m;

  function automatic int eff_m(int r, bit rv, int ra);
    if (r == 0) return 0;
    return cnt_m[r] - ((rv && ra == r && cnt_m[r] != 0) ? 1 : 0);
  endfunction

  function automatic logic [31:0] pend_m();
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < 32; r++) p[r] = (cnt_m[r] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    err_m = 1'b0;
  endtask

  task automatic drive_idle();
    sb_if.issue_valid_i = 1'b0; sb_if.issue_we_i = 1'b0; sb_if.issue_late_i = 1'b0;
    sb_if.issue_waddr_i = '0;   sb_if.id_re1_i = 1'b0;   sb_if.id_raddr1_i = '0;
    sb_if.id_re2_i = 1'b0;      sb_if.id_raddr2_i = '0;  sb_if.ready_valid_i = 1'b0;
    sb_if.ready_waddr_i = '0;   sb_if.flush_i = 1'b0;
  endtask

  task automatic cycle(input bit iv, input bit we, input bit late, input int wa,
                       input bit re1, input int a1, input bit re2, input int a2,
                       input bit rv, input int ra, input bit fl);
    exp_t e;
    bit   st, acc, hit, perr;
    @(negedge clk_i);
    sb_if.issue_valid_i = iv;  sb_if.issue_we_i = we;    sb_if.issue_late_i = late;
    sb_if.issue_waddr_i = 5'(wa);
    sb_if.id_re1_i = re1;      sb_if.id_raddr1_i = 5'(a1);
    sb_if.id_re2_i = re2;      sb_if.id_raddr2_i = 5'(a2);
    sb_if.ready_valid_i = rv;  sb_if.ready_waddr_i = 5'(ra);
    sb_if.flush_i = fl;
    st = iv && !fl && ((re1 && a1 != 0 && eff_m(a1, rv, ra) != 0) ||
                       (re2 && a2 != 0 && eff_m(a2, rv, ra) != 0) ||
                       (we && late && wa != 0 && eff_m(wa, rv, ra) == MAXC));
    e.stall = st; e.pend = pend_m(); e.err = err_m;
    expq.push_back(e);
    acc  = iv && !st && !fl && we && late && wa != 0;
    hit  = rv && ra != 0 && cnt_m[ra] != 0;
    perr = rv && (ra == 0 || cnt_m[ra] == 0);
    @(posedge clk_i);
    if (perr) err_m = 1'b1;
    if (fl) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    end else begin
      if (acc) cnt_m[wa] = cnt_m[wa] + 1;
      if (hit) cnt_m[ra] = cnt_m[ra] - 1;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
            $urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
            $urandom_range(0, 7), $urandom_range(0, 40) == 0);
    end
  endtask

  task automatic check_reset(input string name);
    tests++;
    if (sb_if.stall_o !== 1'b0 || sb_if.pending_o !== '0 || sb_if.err_o !== 1'b0) begin
      fails++;
      $display("FAIL %s: stall=%b pending=%h err=%b, required stall=0 pending=0 err=0",
               name, sb_if.stall_o, sb_if.pending_o, sb_if.err_o);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (sb_if.stall_o !== e.stall) begin
          fails++;
          $display("FAIL stall @%0t: got %b, required %b", $time, sb_if.stall_o, e.stall);
        end
        tests++;
        if (sb_if.pending_o !== e.pend) begin
          fails++;
          $display("FAIL pending @%0t: got %h, required %h", $time, sb_if.pending_o, e.pend);
        end
        tests++;
        if (sb_if.err_o !== e.err) begin
          fails++;
          $display("FAIL err @%0t: got %b, required %b", $time, sb_if.err_o, e.err);
        end
      end
    end
  end

  initial begin : stim
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk_i);
    check_reset("reset_state");
    rst_n_i = 1'b1;

    // load-use on r5, released in the same cycle its ready arrives
    cycle(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 5, 1, 5, 0);
    idle();

    // ready bypass on r7
    cycle(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0);
    idle();

    // saturation on r3: fourth late issue stalls, three readies needed to drain
    repeat (3) cycle(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    idle();

    // flush with cnt[r4]=2 and a coincident ready r4
    cycle(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 4, 1, 4, 1, 4, 1);
    idle();

    // non-late and r0 writes are untracked; r0 source never stalls
    cycle(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 1, 6, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

    // protocol error: ready on idle r9, sticky afterwards
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    rand_cycles(600);

    // asynchronous reset asserted mid-cycle with a reader presented
    @(negedge clk_i);
    #3;
    sb_if.issue_valid_i = 1'b1; sb_if.id_re1_i = 1'b1; sb_if.id_raddr1_i = 5'd3;
    rst_n_i = 1'b0;
    #1;
    check_reset("async_reset");
    model_reset();
    @(negedge clk_i);
    check_reset("reset_held");
    drive_idle();
    rst_n_i = 1'b1;

    rand_cycles(600);

    @(negedge clk_i);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
